mlaccel_comp_decoder: RTL and testbench

//  Receiving end of the sequencer->compute instruction stream (comp_valid/comp_ready/comp_data).

---
 rtl/mlaccel_comp_decoder.sv | 173 +++++++++++++++++
 tb/tb_mlaccel_comp_decoder.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlaccel_comp_decoder.sv
// Instruction decoder at the compute end of the sequencer stream: a 2-entry input FIFO,
// opcode decode, EXECUTE issue with in-flight limiting, CFG pulses and SYNC barriers.
module mlaccel_comp_decoder #(
    parameter int MAX_INFLIGHT = 15,
    parameter int CNT_W        = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         comp_valid,
    output logic         comp_ready,
    input  logic [31:0]  comp_data,
    output logic         exec_valid,
    input  logic         exec_ready,
    output logic [10:0]  exec_addr,
    output logic         exec_last,
    input  logic         exec_done,
    output logic         cfg_valid,
    output logic [5:0]   cfg_opcode,
    output logic [25:0]  cfg_arg,
    output logic         busy,
    output logic         err,
    output logic         dbg_state
);

    // Handshakes: a transfer happens on a rising clock edge where valid && ready are both high;
    // a source holds valid and its payload stable until that edge.

    typedef enum logic {
        S_FETCH     = 1'b0,
        S_SYNC_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t             state;
    state_t             state_next;
    logic [31:0]        fifo_mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         fifo_cnt;
    logic [1:0]         cnt_next;
    logic               push;
    logic               pop;
    logic [31:0]        head;
    logic [5:0]         head_op;
    logic               exec_hs;
    logic [CNT_W-1:0]   inflight;
    logic [CNT_W-1:0]   inflight_next;
    logic               underflow;
    logic               pop_exec;
    logic               pop_cfg;
    logic               pop_sync;
    logic               pop_bad;

    assign push      = comp_valid && comp_ready;
    assign head      = fifo_mem[rd_ptr];
    assign head_op   = head[5:0];
    assign exec_hs   = exec_valid && exec_ready;
    assign dbg_state = state;

    always_comb begin
        inflight_next = inflight;
        underflow     = 1'b0;
        if (exec_hs && !exec_done) begin
            inflight_next = inflight + ONE;
        end else if (!exec_hs && exec_done) begin
            if (inflight == '0) begin
                underflow = 1'b1;
            end else begin
                inflight_next = inflight - ONE;
            end
        end
    end

    // The issue register may be reloaded only once its current op is gone, and the new op must
    // still fit under the in-flight limit once it is accepted.
    always_comb begin
        state_next = state;
        pop_exec   = 1'b0;
        pop_cfg    = 1'b0;
        pop_sync   = 1'b0;
        pop_bad    = 1'b0;
        case (state)
            S_FETCH: begin
                if (fifo_cnt != 2'd0) begin
                    if (head_op == 6'd3) begin
                        if ((!exec_valid || exec_ready) && (inflight_next < MAX_CNT)) begin
                            pop_exec = 1'b1;
                        end
                    end else if (head_op == 6'd0) begin
                        pop_sync   = 1'b1;
                        state_next = S_SYNC_WAIT;
                    end else if ((head_op == 6'd1) || (head_op == 6'd2)) begin
                        pop_bad = 1'b1;
                    end else if (!exec_valid || exec_ready) begin
                        pop_cfg = 1'b1;
                    end
                end
            end
            S_SYNC_WAIT: begin
                if (!exec_valid && (inflight == '0)) begin
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_FETCH;
        endcase
    end

    assign pop = pop_exec || pop_cfg || pop_sync || pop_bad;

    always_comb begin
        case ({push, pop})
            2'b10:   cnt_next = fifo_cnt + 2'd1;
            2'b01:   cnt_next = fifo_cnt - 2'd1;
            default: cnt_next = fifo_cnt;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= comp_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_FETCH;
            fifo_cnt   <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            comp_ready <= 1'b0;
            exec_valid <= 1'b0;
            exec_addr  <= 11'd0;
            exec_last  <= 1'b0;
            cfg_valid  <= 1'b0;
            cfg_opcode <= 6'd0;
            cfg_arg    <= 26'd0;
            busy       <= 1'b0;
            err        <= 1'b0;
            inflight   <= '0;
        end else begin
            state      <= state_next;
            fifo_cnt   <= cnt_next;
            comp_ready <= (cnt_next != 2'd2);
            inflight   <= inflight_next;
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (underflow || pop_bad) begin
                err <= 1'b1;
            end
            if (pop_exec) begin
                exec_valid <= 1'b1;
                exec_addr  <= head[16:6];
                exec_last  <= (head[31:17] == 15'd1);
            end else if (exec_hs) begin
                exec_valid <= 1'b0;
            end
            cfg_valid <= pop_cfg;
            if (pop_cfg) begin
                cfg_opcode <= head_op;
                cfg_arg    <= head[31:6];
            end
            busy <= (fifo_cnt != 2'd0) || exec_valid || (inflight != '0) ||
                    (state == S_SYNC_WAIT);
        end
    end

endmodule

// File: tb/tb_mlaccel_comp_decoder.sv
// Bench for mlaccel_comp_decoder: decode table, directed multi-cycle sequences and a randomized
// run checked against an in-order program model with SYNC completion requirements.
module tb_mlaccel_comp_decoder;

    localparam int MAXI = 15;
    localparam int W    = 64;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         comp_valid = 1'b0;
    logic         comp_ready;
    logic [31:0]  comp_data = 32'd0;
    logic         exec_valid;
    logic         exec_ready = 1'b0;
    logic [10:0]  exec_addr;
    logic         exec_last;
    logic         exec_done = 1'b0;
    logic         cfg_valid;
    logic [5:0]   cfg_opcode;
    logic [25:0]  cfg_arg;
    logic         busy;
    logic         err;
    logic         dbg_state;

    logic         m2_comp_ready, m2_exec_valid, m2_exec_last, m2_cfg_valid;
    logic         m2_busy, m2_err, m2_dbg_state;
    logic [10:0]  m2_exec_addr;
    logic [5:0]   m2_cfg_opcode;
    logic [25:0]  m2_cfg_arg;

    mlaccel_comp_decoder #(.MAX_INFLIGHT(MAXI), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .comp_valid(comp_valid), .comp_ready(comp_ready),
        .comp_data(comp_data), .exec_valid(exec_valid), .exec_ready(exec_ready),
        .exec_addr(exec_addr), .exec_last(exec_last), .exec_done(exec_done),
        .cfg_valid(cfg_valid), .cfg_opcode(cfg_opcode), .cfg_arg(cfg_arg),
        .busy(busy), .err(err), .dbg_state(dbg_state)
    );

    mlaccel_comp_decoder #(.MAX_INFLIGHT(2), .CNT_W(4)) dut2 (
        .clock(clock), .reset(reset), .comp_valid(comp_valid), .comp_ready(m2_comp_ready),
        .comp_data(comp_data), .exec_valid(m2_exec_valid), .exec_ready(exec_ready),
        .exec_addr(m2_exec_addr), .exec_last(m2_exec_last), .exec_done(exec_done),
        .cfg_valid(m2_cfg_valid), .cfg_opcode(m2_cfg_opcode), .cfg_arg(m2_cfg_arg),
        .busy(m2_busy), .err(m2_err), .dbg_state(m2_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    // exp entry: [63:62] kind (1 exec, 2 cfg), [61:32] completed EXECUTEs required, [31:0] payload
    logic [W-1:0] exp_q[$];
    int           ex_cyc_q[$];
    int           total = 0;
    int           bad = 0;
    int           hs_cnt = 0;
    int           done_cnt = 0;
    int           cfg_cnt = 0;
    int           m2_hs_cnt = 0;
    int           sync_req_cur = 0;
    int           exec_prog = 0;
    logic         err_exp = 1'b0;
    logic         model_on = 1'b1;
    logic         t1_watch = 1'b0;
    int           cr_drop = 0;
    logic         prev_hold = 1'b0;
    logic [12:0]  prev_val = 13'd0;
    logic         rnd_stop = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_ev(input logic [33:0] ev);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            check("unexpected_event", {30'd0, ev}, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check("event", {30'd0, ev}, {30'd0, e[63:62], e[31:0]});
            if (e[61:32] != 30'd0) begin
                check("sync_barrier", {63'd0, (done_cnt >= int'(e[61:32]))}, 64'd1);
            end
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (exec_done) done_cnt++;
            if (exec_valid && exec_ready) begin
                hs_cnt++;
                ex_cyc_q.push_back(cyc);
                check_ev({2'd1, 20'd0, exec_addr, exec_last});
                check("inflight_limit", {63'd0, ((hs_cnt - done_cnt) <= MAXI)}, 64'd1);
            end
            if (cfg_valid) begin
                cfg_cnt++;
                check_ev({2'd2, cfg_opcode, cfg_arg});
            end
            if (m2_exec_valid && exec_ready) m2_hs_cnt++;
            if (prev_hold) check("exec_hold", {51'd0, exec_valid, exec_addr, exec_last}, {51'd0, prev_val});
            prev_hold = exec_valid && !exec_ready;
            prev_val  = {exec_valid, exec_addr, exec_last};
            if (t1_watch && !comp_ready) cr_drop++;
        end
    end

    // ---------------- model + driver tasks ----------------
    task automatic model_accept(input logic [31:0] w);
        case (w[5:0])
            6'd0: sync_req_cur = exec_prog;
            6'd1, 6'd2: err_exp = 1'b1;
            6'd3: begin
                exp_q.push_back({2'd1, 30'(sync_req_cur), 20'd0, w[16:6], (w[31:17] == 15'd1)});
                exec_prog++;
            end
            default: exp_q.push_back({2'd2, 30'(sync_req_cur), w[5:0], w[31:6]});
        endcase
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [31:0] w, output int hc);
        int n = 0;
        comp_valid = 1'b1;
        comp_data  = w;
        @(negedge clock);
        while (!comp_ready && n < 1000) begin
            @(negedge clock);
            n++;
        end
        hc = cyc;
        if (!comp_ready) check("push_timeout", 64'd0, 64'd1);
        else if (model_on) model_accept(w);
        step();
        comp_valid = 1'b0;
    endtask

    task automatic pulse_done();
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        exp_q.delete();
        ex_cyc_q.delete();
        hs_cnt = 0; done_cnt = 0; cfg_cnt = 0; m2_hs_cnt = 0;
        sync_req_cur = 0; exec_prog = 0; err_exp = 1'b0;
        reset = 1'b0;
        step();
    endtask

    function automatic logic [31:0] exec_word(input logic [14:0] c, input logic [10:0] a);
        return {c, a, 6'd3};
    endfunction

    typedef struct {
        logic [31:0] word;
        logic [1:0]  kind;
        logic [31:0] payload;
        logic        err;
    } vec_t;

    vec_t tbl[10];

    // ---------------- test sequence ----------------
    initial begin
        int hc;
        int h0;
        int n;
        logic [31:0] w;
        int r;

        tbl[0] = '{word: {15'd1, 11'h7ff, 6'd3},     kind: 2'd1, payload: {20'd0, 11'h7ff, 1'b1}, err: 1'b0};
        tbl[1] = '{word: {15'd2, 11'h000, 6'd3},     kind: 2'd1, payload: {20'd0, 11'h000, 1'b0}, err: 1'b0};
        tbl[2] = '{word: {15'd0, 11'h155, 6'd3},     kind: 2'd1, payload: {20'd0, 11'h155, 1'b0}, err: 1'b0};
        tbl[3] = '{word: {15'h7fff, 11'h2aa, 6'd3},  kind: 2'd1, payload: {20'd0, 11'h2aa, 1'b0}, err: 1'b0};
        tbl[4] = '{word: {26'h0000123, 6'd4},        kind: 2'd2, payload: {6'd4, 26'h0000123},   err: 1'b0};
        tbl[5] = '{word: {26'h3ffffff, 6'd63},       kind: 2'd2, payload: {6'd63, 26'h3ffffff},  err: 1'b0};
        tbl[6] = '{word: {26'h2aaaaaa, 6'd17},       kind: 2'd2, payload: {6'd17, 26'h2aaaaaa},  err: 1'b0};
        tbl[7] = '{word: {26'h0000155, 6'd1},        kind: 2'd0, payload: 32'd0,                 err: 1'b1};
        tbl[8] = '{word: {26'h0000000, 6'd2},        kind: 2'd0, payload: 32'd0,                 err: 1'b1};
        tbl[9] = '{word: {26'h00003ff, 6'd0},        kind: 2'd0, payload: 32'd0,                 err: 1'b0};

        // reset state
        step();
        @(negedge clock);
        check("reset_state", {15'd0, comp_ready, exec_valid, exec_addr, exec_last, cfg_valid,
                              cfg_opcode, cfg_arg, busy, err}, 64'd0);
        do_reset();
        @(negedge clock);
        check("ready_after_reset", {63'd0, comp_ready}, 64'd1);
        step();

        // decode table
        model_on = 1'b0;
        for (int i = 0; i < 10; i++) begin
            do_reset();
            exec_ready = 1'b1;
            if (tbl[i].kind != 2'd0) exp_q.push_back({tbl[i].kind, 30'd0, tbl[i].payload});
            push(tbl[i].word, hc);
            repeat (6) step();
            check($sformatf("tbl%0d_drain", i), 64'(exp_q.size()), 64'd0);
            check($sformatf("tbl%0d_err", i), {63'd0, err}, {63'd0, tbl[i].err});
        end
        model_on = 1'b1;

        // back-to-back EXECUTEs, two-cycle latency, no ready drop
        do_reset();
        exec_ready = 1'b1;
        t1_watch = 1'b1;
        push(exec_word(15'd3, 11'd5), h0);
        push(exec_word(15'd2, 11'd6), hc);
        push(exec_word(15'd1, 11'd7), hc);
        repeat (6) step();
        t1_watch = 1'b0;
        check("t1_issued", 64'(ex_cyc_q.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (ex_cyc_q.size() > 0) check($sformatf("t1_cycle%0d", i), 64'(ex_cyc_q.pop_front() - h0), 64'(i + 2));
        end
        check("t1_ready_drop", 64'(cr_drop), 64'd0);
        check("t1_drain", 64'(exp_q.size()), 64'd0);

        // back-pressure: 3 accepted, 4th waits, payload held
        do_reset();
        exec_ready = 1'b0;
        fork
            begin
                push(exec_word(15'd4, 11'h10), hc);
                push(exec_word(15'd3, 11'h11), hc);
                push(exec_word(15'd2, 11'h12), hc);
                push(exec_word(15'd1, 11'h13), hc);
            end
            begin
                repeat (12) @(negedge clock);
                check("t2_ready_low", {63'd0, comp_ready}, 64'd0);
                check("t2_accepted", 64'(exec_prog), 64'd3);
                check("t2_held", {51'd0, exec_valid, exec_addr, exec_last}, {51'd0, 1'b1, 11'h10, 1'b0});
                step();
                exec_ready = 1'b1;
            end
        join
        repeat (6) step();
        check("t2_all_issued", 64'(hs_cnt), 64'd4);
        check("t2_drain", 64'(exp_q.size()), 64'd0);

        // in-flight limit on the MAX_INFLIGHT=2 instance
        do_reset();
        exec_ready = 1'b1;
        push(exec_word(15'd1, 11'd1), hc);
        push(exec_word(15'd1, 11'd2), hc);
        push(exec_word(15'd1, 11'd3), hc);
        repeat (10) step();
        check("t3_limited", 64'(m2_hs_cnt), 64'd2);
        pulse_done();
        repeat (5) step();
        check("t3_third_issued", 64'(m2_hs_cnt), 64'd3);

        // SYNC barrier then CFG
        do_reset();
        exec_ready = 1'b1;
        push(exec_word(15'd1, 11'd9), hc);
        push({26'd0, 6'd0}, hc);
        push({26'h123, 6'd4}, hc);
        repeat (10) step();
        @(negedge clock);
        check("t4_cfg_blocked", 64'(cfg_cnt), 64'd0);
        check("t4_sync_state", {62'd0, busy, dbg_state}, 64'd3);
        step();
        pulse_done();
        n = 0;
        @(negedge clock);
        while (!cfg_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("t4_cfg_seen", {63'd0, cfg_valid}, 64'd1);
        check("t4_busy_at_cfg", {63'd0, busy}, 64'd1);
        @(negedge clock);
        check("t4_cfg_pulse_busy_fall", {62'd0, cfg_valid, busy}, 64'd0);
        check("t4_drain", 64'(exp_q.size()), 64'd0);

        // error sources
        do_reset();
        pulse_done();
        @(negedge clock);
        check("t5_underflow_err", {63'd0, err}, 64'd1);
        step();
        do_reset();
        exec_ready = 1'b1;
        push({26'h5, 6'd1}, hc);
        repeat (3) step();
        check("t5_call_err", {63'd0, err}, {63'd0, err_exp});
        pulse_done();
        push(exec_word(15'd1, 11'h44), hc);
        repeat (5) step();
        check("t5_exec_after_err", 64'(exp_q.size()), 64'd0);
        check("t5_err_sticky", {63'd0, err}, 64'd1);

        // reset while FIFO full and issue held
        do_reset();
        exec_ready = 1'b0;
        push(exec_word(15'd1, 11'd1), hc);
        push(exec_word(15'd1, 11'd2), hc);
        push(exec_word(15'd1, 11'd3), hc);
        @(negedge clock);
        check("t6_full", {62'd0, comp_ready, exec_valid}, 64'd1);
        step();
        reset = 1'b1;
        step();
        @(negedge clock);
        check("t6_outputs_zero", {15'd0, comp_ready, exec_valid, exec_addr, exec_last, cfg_valid,
                                  cfg_opcode, cfg_arg, busy, err}, 64'd0);
        step();
        exp_q.delete();
        hs_cnt = 0; done_cnt = 0; cfg_cnt = 0; exec_prog = 0; sync_req_cur = 0; err_exp = 1'b0;
        reset = 1'b0;
        step();
        exec_ready = 1'b1;
        repeat (5) step();
        check("t6_fifo_empty", {31'd0, 32'(hs_cnt), busy}, 64'd0);
        pulse_done();
        @(negedge clock);
        check("t6_inflight_cleared", {63'd0, err}, 64'd1);
        step();

        // randomized run against the program model
        do_reset();
        rnd_stop = 1'b0;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    r = $urandom_range(0, 99);
                    if (r < 50) begin
                        case ($urandom_range(0, 3))
                            0: w = exec_word(15'd0, 11'($urandom));
                            1: w = exec_word(15'd1, 11'($urandom));
                            2: w = exec_word(15'd2, 11'($urandom));
                            default: w = exec_word(15'($urandom), 11'($urandom));
                        endcase
                    end else if (r < 80) begin
                        w = {26'($urandom), 6'($urandom_range(4, 63))};
                    end else if (r < 94) begin
                        w = {26'($urandom), 6'd0};
                    end else begin
                        w = {26'($urandom), 6'($urandom_range(1, 2))};
                    end
                    push(w, hc);
                    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
                end
                n = 0;
                while ((exp_q.size() != 0 || hs_cnt != done_cnt) && n < 3000) begin
                    step();
                    n++;
                end
                rnd_stop = 1'b1;
            end
            begin
                while (!rnd_stop) begin
                    step();
                    exec_ready = ($urandom_range(0, 9) < 7);
                end
                exec_ready = 1'b1;
            end
            begin
                while (!rnd_stop) begin
                    step();
                    exec_done = ((hs_cnt - done_cnt) > 0) && ($urandom_range(0, 3) == 0);
                end
                exec_done = 1'b0;
            end
        join
        repeat (4) step();
        check("rnd_drain", 64'(exp_q.size()), 64'd0);
        check("rnd_done_balance", 64'(hs_cnt - done_cnt), 64'd0);
        check("rnd_err", {63'd0, err}, {63'd0, err_exp});
        check("rnd_idle", {62'd0, busy, dbg_state}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
